task2_adder: RTL and testbench

- Unsigned WIDTH-bit adder with a registered (WIDTH+1)-bit sum, so the carry-out is never lost.
- Core is a structural ripple-carry chain of full-adder cells; the sum is captured in an output register.
- Used as the basic-drill arithmetic block. Its bench sweeps all 6-bit operand pairs.

---
 rtl/task2_adder.sv | 57 +++++
 tb/tb_task2_adder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/task2_adder.sv
// -----------------------------------------------------------------------------
// task2_adder
//
// Unsigned WIDTH-bit adder with a registered (WIDTH+1)-bit sum. The core is a
// ripple chain of full-adder cells. The carry-out of the last cell becomes the
// top bit of the sum, so no result can overflow.
//
// Ports:
//   i_w_clk      - system clock, rising-edge active
//   i_w_reset_n  - asynchronous active-low reset; clears the sum register
//   i_w_a        - operand A, unsigned, WIDTH bits
//   i_w_b        - operand B, unsigned, WIDTH bits
//   o_w_s        - registered A+B, WIDTH+1 bits; bit WIDTH is the carry-out
//
// Latency is one clock. A new operand pair is accepted on every cycle.
// -----------------------------------------------------------------------------
module task2_adder #(
  parameter int WIDTH = 6
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset_n,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic [WIDTH:0]   o_w_s
);

  // carry[i] is the carry into cell i. carry[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   s_p1;

  assign carry[0] = 1'b0;

  // Stage p0: combinational ripple-carry chain
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_bits[i] = i_w_a[i] ^ i_w_b[i] ^ carry[i];
    assign carry[i+1]  = (i_w_a[i] & i_w_b[i])
                       | (i_w_a[i] & carry[i])
                       | (i_w_b[i] & carry[i]);
  end

  assign sum_p0 = {carry[WIDTH], sum_bits};

  // Stage p1: output register. The sum is cleared as soon as reset asserts,
  // so the output is never left holding a stale result.
  always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
    if (!i_w_reset_n) begin
      s_p1 <= '0;
    end else begin
      s_p1 <= sum_p0;
    end
  end

  assign o_w_s = s_p1;

endmodule

// File: tb/tb_task2_adder.sv
// -----------------------------------------------------------------------------
// tb_task2_adder
//
// Directed and exhaustive stimulus for task2_adder with WIDTH=6. Inputs change
// 1 time unit after a rising edge. Outputs are sampled 1 time unit after the
// rising edge, so they are read away from the active edge.
// -----------------------------------------------------------------------------
module tb_task2_adder;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   s;

  int total = 0;
  int bad   = 0;

  task2_adder #(.WIDTH(WIDTH)) dut (
    .i_w_clk     (clk),
    .i_w_reset_n (rst_n),
    .i_w_a       (a),
    .i_w_b       (b),
    .o_w_s       (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH:0] got,
                     input logic [WIDTH:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Apply one operand pair, then check the result one edge later.
  task automatic step(input string tag, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic [WIDTH:0] want);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    chk(tag, s, want);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 6'd63;
    b     = 6'd63;
    #1;
    chk("reset_async_start", s, 7'd0);

    // Hold reset across several edges while the operands are nonzero.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", s, 7'd0);

    // Release reset. The next edge loads 63+63.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", s, 7'd126);

    // Zero and identity cases
    step("zero",     6'd0,  6'd0,  7'd0);
    step("ident_a",  6'd37, 6'd0,  7'd37);
    step("ident_b",  6'd0,  6'd21, 7'd21);

    // Carry propagation cases
    step("carry_63_1",  6'd63, 6'd1,  7'd64);
    step("carry_32_32", 6'd32, 6'd32, 7'd64);
    step("carry_max",   6'd63, 6'd63, 7'd126);

    // Check that the output holds between edges while the operands change.
    a = 6'd1;
    b = 6'd2;
    #3;
    chk("hold_between_edges", s, 7'd126);
    @(posedge clk);
    #1;
    chk("hold_then_load", s, 7'd3);

    // Back-to-back pairs: each result lags its operands by one edge.
    a = 6'd5;
    b = 6'd7;
    @(posedge clk);
    #1;
    chk("lat_1", s, 7'd12);
    a = 6'd10;
    b = 6'd20;
    #2;
    chk("lat_1_hold", s, 7'd12);
    @(posedge clk);
    #1;
    chk("lat_2", s, 7'd30);
    a = 6'd1;
    b = 6'd62;
    @(posedge clk);
    #1;
    chk("lat_3", s, 7'd63);

    // Assert reset mid-stream, between edges, while the output is 126.
    step("pre_async", 6'd63, 6'd63, 7'd126);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mid", s, 7'd0);
    @(posedge clk);
    #1;
    chk("async_held", s, 7'd0);
    rst_n = 1'b1;
    a     = 6'd40;
    b     = 6'd3;
    @(posedge clk);
    #1;
    chk("post_reset_load", s, 7'd43);

    // Exhaustive sweep, one new pair every cycle.
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        logic [WIDTH:0] want;
        want = 7'(ia + ib);
        step("sweep", 6'(ia), 6'(ib), want);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
